// File: rtl/run_step_ctrl.sv
// Execution controller for the pipelined RISC-V core: debounced buttons drive
// PAUSE/STEP/RUN/BREAK modes, generating cpu_ce, a step counter and the display word.
module run_step_ctrl #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned RUN_DIV     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce1ms,
  input  logic        btn_step,
  input  logic        btn_mode,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        disp_sel,
  output logic        cpu_ce,
  output logic [31:0] disp_word,
  output logic [31:0] cycle_count,
  output logic [1:0]  state,
  output logic        halted
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned RD_W = $clog2(RUN_DIV + 1);

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } stateT;

  stateT stateQ, stateNext;

  // Index 0 = step button, index 1 = mode button.
  logic [1:0]      btnRaw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      debLevel, debLevelD;
  logic [DB_W-1:0] dbCnt [2];
  logic [1:0]      press;
  logic            stepP, modeP;

  logic [RD_W-1:0] rateCnt;
  logic            firePoint;
  logic            bpSkip, bpSkipNext;
  logic            ceNext;

  assign btnRaw = {btn_mode, btn_step};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      debLevel  <= '0;
      debLevelD <= '0;
      for (int unsigned i = 0; i < 2; i++) dbCnt[i] <= '0;
    end else begin
      sync1     <= btnRaw;
      sync2     <= sync1;
      debLevelD <= debLevel;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == debLevel[i]) begin
          dbCnt[i] <= '0;
        end else if (ce1ms) begin
          if (dbCnt[i] == DB_W'(DEBOUNCE_MS - 1)) begin
            debLevel[i] <= sync2[i];
            dbCnt[i]    <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign press = debLevel & ~debLevelD;
  assign stepP = press[0];
  assign modeP = press[1];

  assign firePoint = ce1ms && (rateCnt == RD_W'(RUN_DIV - 1));

  // mode_p is tested before step_p everywhere so it wins on a tie.
  always_comb begin
    stateNext  = stateQ;
    ceNext     = 1'b0;
    bpSkipNext = bpSkip;
    unique case (stateQ)
      S_PAUSE: begin
        if (modeP) begin
          stateNext = S_RUN;
        end else if (stepP) begin
          stateNext = S_STEP;
          ceNext    = 1'b1;
        end
      end
      S_STEP: stateNext = S_PAUSE;
      S_RUN: begin
        if (modeP) begin
          stateNext = S_PAUSE;
        end else if (firePoint) begin
          if (bp_en && (pc == bp_addr) && !bpSkip) begin
            stateNext = S_BREAK;
          end else begin
            ceNext     = 1'b1;
            bpSkipNext = 1'b0;
          end
        end
      end
      S_BREAK: begin
        if (modeP) begin
          stateNext  = S_RUN;
          bpSkipNext = 1'b1;
        end else if (stepP) begin
          stateNext = S_STEP;
          ceNext    = 1'b1;
        end
      end
      default: stateNext = S_PAUSE;
    endcase
  end

  // Holding the rate counter at zero outside RUN gives the clear-on-entry behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= S_PAUSE;
      cpu_ce      <= 1'b0;
      bpSkip      <= 1'b0;
      rateCnt     <= '0;
      cycle_count <= '0;
      disp_word   <= '0;
    end else begin
      stateQ <= stateNext;
      cpu_ce <= ceNext;
      bpSkip <= bpSkipNext;
      if (stateQ != S_RUN) begin
        rateCnt <= '0;
      end else if (ce1ms) begin
        rateCnt <= firePoint ? '0 : rateCnt + 1'b1;
      end
      if (cpu_ce) cycle_count <= cycle_count + 32'd1;
      disp_word <= disp_sel ? instr : pc;
    end
  end

  assign state  = stateQ;
  assign halted = (stateQ == S_BREAK);

endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed bench for run_step_ctrl with DEBOUNCE_MS=2, RUN_DIV=3.
module tb_run_step_ctrl;

  logic        clk;
  logic        reset;
  logic        ce1ms;
  logic        btn_step;
  logic        btn_mode;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        disp_sel;
  logic        cpu_ce;
  logic [31:0] disp_word;
  logic [31:0] cycle_count;
  logic [1:0]  state;
  logic        halted;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;
  int unsigned pulses;
  logic        autoPc;

  run_step_ctrl #(.DEBOUNCE_MS(2), .RUN_DIV(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce1ms      (ce1ms),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .instr      (instr),
    .disp_sel   (disp_sel),
    .cpu_ce     (cpu_ce),
    .disp_word  (disp_word),
    .cycle_count(cycle_count),
    .state      (state),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; on the falling edge count cpu_ce pulses and advance the bench core PC.
  task automatic cyc();
    @(negedge clk);
    if (cpu_ce === 1'b1) begin
      pulses++;
      if (autoPc) pc = pc + 32'd4;
    end
  endtask

  task automatic tick();
    ce1ms = 1'b1;
    cyc();
    ce1ms = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic doReset();
    btn_step = 1'b0;
    btn_mode = 1'b0;
    reset    = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic pressMode();
    btn_mode = 1'b1;
    repeat (3) cyc();
    tick();
    tick();
    btn_mode = 1'b0;
  endtask

  task automatic pressStep();
    btn_step = 1'b1;
    repeat (3) cyc();
    tick();
    tick();
    btn_step = 1'b0;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    failed   = 0;
    pulses   = 0;
    autoPc   = 1'b0;
    reset    = 1'b1;
    ce1ms    = 1'b0;
    btn_step = 1'b0;
    btn_mode = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'h0;
    pc       = 32'h1234;
    instr    = 32'h0;
    disp_sel = 1'b0;

    // Reset values
    repeat (3) cyc();
    check("rst state", {30'b0, state}, 32'd0);
    check("rst cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("rst disp_word", disp_word, 32'd0);
    check("rst cycle_count", cycle_count, 32'd0);
    check("rst halted", {31'b0, halted}, 32'd0);
    reset = 1'b0;
    pc    = 32'h0;
    cyc();

    // Reset while RUN is active with btn_mode held
    btn_mode = 1'b1;
    repeat (3) cyc();
    tick();
    tick();
    check("pre-rst run", {30'b0, state}, 32'd2);
    repeat (3) tick();
    check("pre-rst count", cycle_count, 32'd1);
    reset = 1'b1;
    cyc();
    check("mid-rst state", {30'b0, state}, 32'd0);
    check("mid-rst cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("mid-rst count", cycle_count, 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    tick();
    check("held 1 tick", {30'b0, state}, 32'd0);
    tick();
    check("held 2 ticks", {30'b0, state}, 32'd2);

    // Glitch on btn_step shorter than the debounce window
    doReset();
    pulses   = 0;
    btn_step = 1'b1;
    repeat (3) cyc();
    tick();
    btn_step = 1'b0;
    repeat (3) cyc();
    tick();
    tick();
    check("glitch pulses", pulses, 32'd0);
    check("glitch state", {30'b0, state}, 32'd0);

    // Debounced step press
    btn_step = 1'b1;
    repeat (3) cyc();
    tick();
    ce1ms = 1'b1;
    cyc();
    ce1ms = 1'b0;
    cyc();
    check("step state", {30'b0, state}, 32'd1);
    check("step cpu_ce", {31'b0, cpu_ce}, 32'd1);
    cyc();
    check("step back", {30'b0, state}, 32'd0);
    check("step ce off", {31'b0, cpu_ce}, 32'd0);
    check("step count", cycle_count, 32'd1);
    tick();
    btn_step = 1'b0;
    repeat (3) cyc();
    tick();
    tick();
    check("step pulses", pulses, 32'd1);

    // Run rate: one step every three ticks
    doReset();
    pulses = 0;
    pressMode();
    check("run entry", {30'b0, state}, 32'd2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("run pulses", pulses, 32'(k / 3));
    end
    check("run count", cycle_count, 32'd3);
    pressMode();
    check("run pause", {30'b0, state}, 32'd0);
    repeat (6) tick();
    check("paused pulses", pulses, 32'd3);
    check("paused count", cycle_count, 32'd3);

    // Breakpoint at PC 0x10
    doReset();
    pulses  = 0;
    pc      = 32'h0;
    autoPc  = 1'b1;
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    pressMode();
    repeat (3) tick();
    check("bp pc1", pc, 32'h4);
    repeat (3) tick();
    check("bp pc2", pc, 32'h8);
    repeat (3) tick();
    check("bp pc3", pc, 32'hC);
    repeat (3) tick();
    check("bp pc4", pc, 32'h10);
    check("bp pulses", pulses, 32'd4);
    repeat (3) tick();
    check("bp state", {30'b0, state}, 32'd3);
    check("bp halted", {31'b0, halted}, 32'd1);
    check("bp count", cycle_count, 32'd4);
    check("bp pc held", pc, 32'h10);
    pressMode();
    check("bp resume", {30'b0, state}, 32'd2);
    check("bp unhalted", {31'b0, halted}, 32'd0);
    repeat (3) tick();
    check("bp skip pc", pc, 32'h14);
    check("bp skip count", cycle_count, 32'd5);
    autoPc = 1'b0;
    bp_en  = 1'b0;

    // Simultaneous mode and step presses
    doReset();
    pulses   = 0;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    repeat (3) cyc();
    tick();
    ce1ms = 1'b1;
    cyc();
    ce1ms = 1'b0;
    cyc();
    check("simul state", {30'b0, state}, 32'd2);
    check("simul cpu_ce", {31'b0, cpu_ce}, 32'd0);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    cyc();
    check("simul pulses", pulses, 32'd0);

    // cycle_count wraps
    doReset();
    force dut.cycle_count = 32'hFFFF_FFFF;
    cyc();
    release dut.cycle_count;
    cyc();
    check("wrap preload", cycle_count, 32'hFFFF_FFFF);
    pressStep();
    check("wrap count", cycle_count, 32'h0);

    // Display mux lags one clock
    pc       = 32'h8;
    instr    = 32'h0050_0113;
    disp_sel = 1'b0;
    cyc();
    check("disp pc", disp_word, 32'h8);
    disp_sel = 1'b1;
    check("disp lag", disp_word, 32'h8);
    cyc();
    check("disp instr", disp_word, 32'h0050_0113);
    disp_sel = 1'b0;
    cyc();
    check("disp back", disp_word, 32'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/run_step_ctrl.md
# run_step_ctrl

Execution controller for the pipelined RISC-V core. It generates the processor clock-enable from debounced front-panel buttons. It supports paused, single-step and free-run modes at a programmable rate, plus one PC breakpoint. It also keeps a retired-step counter and selects the word shown on the seven-segment display. It sits between the `gen1ms` tick, the buttons and the `riscvsingle`/`dmem`/`rwb` enable inputs.

## Interface
- `DEBOUNCE_MS`, 20: consecutive `ce1ms` ticks a button level must hold before it is accepted (≥1).
- `RUN_DIV`, 1000: `ce1ms` ticks per processor step in RUN mode (≥1).
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `ce1ms` in 1: one-`clk` pulse every 1 ms.
- `btn_step` in 1: raw, asynchronous step button, high = pressed.
- `btn_mode` in 1: raw, asynchronous run/pause button, high = pressed.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC.
- `pc` in 32: current fetch PC from the core.
- `instr` in 32: fetched instruction.
- `disp_sel` in 1: 0 = show `pc`, 1 = show `instr`.
- `cpu_ce` out 1: processor/memory enable; one-`clk` pulse per step; registered.
- `disp_word` out 32: registered display word.
- `cycle_count` out 32: number of `cpu_ce` pulses issued; registered.
- `state` out 2: 0 PAUSE, 1 STEP, 2 RUN, 3 BREAK.
- `halted` out 1: high while `state`==BREAK.

## Operation
- **Input conditioning:** each button has a 2-flop synchronizer followed by a debouncer.
  - The debounce counter counts `ce1ms` ticks while the synchronized level differs from the debounced level. It clears whenever the two are equal.
  - When the counter reaches `DEBOUNCE_MS`, the debounced level takes the synchronized value and the counter clears.
  - A debounced 0→1 edge produces a one-`clk` press pulse: `step_p` or `mode_p`.
- **FSM:**
  - PAUSE: `mode_p` → RUN. `step_p` → STEP.
  - STEP: lasts exactly one cycle with `cpu_ce`=1, then returns to PAUSE unconditionally. Presses arriving during STEP are dropped.
  - RUN: a rate counter (0..`RUN_DIV`-1) increments on each `ce1ms` tick. A tick that finds the counter at `RUN_DIV`-1 is a fire point, and the counter wraps to 0.
    - At a fire point with `bp_en`=1, `pc`==`bp_addr` and `bp_skip`=0: go to BREAK, with no `cpu_ce`.
    - At any other fire point: `cpu_ce`=1 for that cycle and `bp_skip` clears.
    - `mode_p` → PAUSE.
  - BREAK: `mode_p` → RUN and set `bp_skip`, so the next fire point ignores the breakpoint. `step_p` → STEP.
- **Simultaneous events:** `mode_p` and `step_p` in the same cycle: `mode_p` wins and `step_p` is discarded.
- **Rate counter:** clears on every entry to RUN, so the first step occurs `RUN_DIV` ticks after entry.
- **`cycle_count`:** increments by 1 on each edge at which `cpu_ce`=1. It is modulo 2^32 (0xFFFFFFFF → 0).
- **`disp_word`:** updated every `clk` from `pc` or `instr` according to `disp_sel`.
- **Reset:** clears all state, including mid-RUN or mid-STEP.
  - Clears the debounced levels to 0. A button held through reset release therefore yields a press `DEBOUNCE_MS` ticks later.
  - Clears `bp_skip` and both counters.

## Timing
- Reset values: `cpu_ce`=0, `disp_word`=0, `cycle_count`=0, `state`=0 (PAUSE), `halted`=0.
- Press latency:
  - 2 `clk` for synchronization, then `DEBOUNCE_MS` `ce1ms` ticks, then the press pulse.
  - The FSM changes state on the edge following the pulse.
  - `cpu_ce` is high in the first cycle `state`==STEP.
- RUN fire: `cpu_ce` is high in the cycle immediately after the `ce1ms` tick that completes the count.
- Breakpoint compare uses `pc` sampled in the fire-point cycle.
- `cycle_count` updates one edge after each `cpu_ce` pulse.
- `disp_word` lags `pc`/`instr`/`disp_sel` by 1 `clk`.
- `cpu_ce` is never high for two consecutive cycles.

## Test plan
All scenarios use `DEBOUNCE_MS`=2 and `RUN_DIV`=3.
- **Reset:** assert `reset` for 3 cycles while RUN is active and `btn_mode` is held → next edge gives `state`=0, `cpu_ce`=0, `cycle_count`=0. Release `reset` with the button still held → RUN is entered only after 2 more ticks.
- **Debounce/step:**
  - `btn_step` high for 1 tick then low → no pulse.
  - `btn_step` high for 3 ticks → exactly one `cpu_ce` pulse, `state` goes 1 then 0, `cycle_count`=1.
- **Run rate:** `mode_p`, then 9 `ce1ms` ticks → 3 `cpu_ce` pulses, on ticks 3, 6 and 9, and `cycle_count`=3. A further `mode_p` → PAUSE and no pulses over 6 more ticks.
- **Breakpoint:** bench adds 4 to `pc` per `cpu_ce`, starting at 0. Set `bp_en`=1, `bp_addr`=0x10, then RUN →
  - pulses at `pc` 0, 4, 8, 0xC;
  - then `state`=3, `halted`=1, `cycle_count`=4;
  - `mode_p` → next fire issues `cpu_ce` with `pc`=0x10, and `pc` goes to 0x14.
- **Simultaneous:** `mode_p` and `step_p` on the same cycle in PAUSE → `state`=2, no `cpu_ce` that cycle.
- **Wrap/display:**
  - Force `cycle_count`=0xFFFFFFFF via a bench preload (hierarchical force), then step → 0.
  - Toggle `disp_sel` with `pc`=0x8, `instr`=0x00500113 → `disp_word` follows 1 cycle later.
